muldiv_hilo_ctrl: RTL and testbench

//   Multi-cycle multiply/divide sequencer owning the HI/LO register pair.

---
 rtl/muldiv_hilo_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: multi-cycle multiply/divide sequencer owning HI/LO.
// Shift-add multiply and restoring divide, WIDTH iterations, one sign-fixup
// cycle, then a one-cycle DONE that presents the freshly committed HI/LO.
// Optional feature: define MULDIV_ABORT_EN to add an `abort` input that
// cancels an operation in RUN/FIX without touching HI/LO or div_zero.
//
// Handshake: an operation is accepted on a rising edge where start & ready
// is high; ready is high in IDLE and DONE, busy in RUN and FIX; done is a
// single-cycle pulse in DONE with outHI/outLO already holding the result.
module muldiv_hilo_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
`ifdef MULDIV_ABORT_EN
    input  logic             abort,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] outHI,
    output logic [WIDTH-1:0] outLO
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;     // mult: upper accumulator, div: partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;     // mult: multiplier/low product, div: dividend/quotient
    logic [WIDTH-1:0] aop_q, aop_d;     // mult: |multiplicand|, div: |divisor|
    logic [WIDTH-1:0] araw_q, araw_d;   // raw dividend for the divide-by-zero HI value
    logic             div_q, div_d;
    logic             neg_q, neg_d;     // product / quotient needs negation
    logic             rneg_q, rneg_d;   // remainder takes the dividend's sign
    logic             bz_q, bz_d;       // divisor was zero
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;

    logic             abort_w;
    logic             accept;

`ifdef MULDIV_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign accept = start & ready;

    // State and datapath registers, async active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            aop_q   <= '0;
            araw_q  <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            bz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            aop_q   <= aop_d;
            araw_q  <= araw_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            bz_q    <= bz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_RUN;
            S_RUN: begin
                if (abort_w)            state_d = S_IDLE;
                else if (cnt_q == '0)   state_d = S_FIX;
            end
            S_FIX:  state_d = abort_w ? S_IDLE : S_DONE;
            S_DONE: state_d = accept ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        ready    = (state_q == S_IDLE) || (state_q == S_DONE);
        busy     = (state_q == S_RUN)  || (state_q == S_FIX);
        done     = (state_q == S_DONE);
        div_zero = dz_q;
        outHI    = hi_q;
        outLO    = lo_q;
    end

    // Datapath: operand capture, iteration, sign fixup / commit, mthi/mtlo
    always_comb begin
        logic             sa, sb;
        logic [WIDTH-1:0] a_abs, b_abs;
        logic [WIDTH:0]   sum, shifted, diff;
        logic [2*WIDTH-1:0] prod;

        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        aop_d  = aop_q;
        araw_d = araw_q;
        div_d  = div_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        bz_d   = bz_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        dz_d   = dz_q;

        sa      = is_signed & A[WIDTH-1];
        sb      = is_signed & B[WIDTH-1];
        a_abs   = sa ? -A : A;
        b_abs   = sb ? -B : B;
        sum     = {1'b0, rem_q} + (quo_q[0] ? {1'b0, aop_q} : '0);
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, aop_q};
        prod    = {rem_q, quo_q};

        if (accept) begin
            cnt_d  = CW'(WIDTH - 1);
            rem_d  = '0;
            quo_d  = op_div ? a_abs : b_abs;
            aop_d  = op_div ? b_abs : a_abs;
            araw_d = A;
            div_d  = op_div;
            neg_d  = sa ^ sb;
            rneg_d = sa;
            bz_d   = op_div & (B == '0);
            dz_d   = 1'b0;
        end else if (state_q == S_RUN && !abort_w) begin
            cnt_d = cnt_q - 1'b1;
            if (div_q) begin
                // Restoring step: keep the subtraction only when it does not borrow
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                // Shift-add step: carry of the add shifts into the accumulator
                rem_d = sum[WIDTH:1];
                quo_d = {sum[0], quo_q[WIDTH-1:1]};
            end
        end else if (state_q == S_FIX && !abort_w) begin
            if (div_q) begin
                if (bz_q) begin
                    lo_d = '1;
                    hi_d = araw_q;
                    dz_d = 1'b1;
                end else begin
                    lo_d = neg_q  ? -quo_q : quo_q;
                    hi_d = rneg_q ? -rem_q : rem_q;
                end
            end else begin
                if (neg_q) prod = -prod;
                hi_d = prod[2*WIDTH-1:WIDTH];
                lo_d = prod[WIDTH-1:0];
            end
        end

        // Register moves only when idle-ready and not starting; start wins
        if (ready && !start) begin
            if (mthi) hi_d = wdata;
            if (mtlo) lo_d = wdata;
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb_muldiv_hilo_ctrl: directed + random checks of muldiv_hilo_ctrl with a
// scoreboard of expected HI/LO/div_zero filled at accept and drained at done.
// Compile with +define+MULDIV_ABORT_EN to also exercise the abort input.
module tb_muldiv_hilo_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        op_div;
    logic        is_signed;
    logic [31:0] A;
    logic [31:0] B;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
`ifdef MULDIV_ABORT_EN
    logic        abort;
`endif
    logic        ready;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] outHI;
    logic [31:0] outLO;

    logic [31:0] exp_hi_q[$];
    logic [31:0] exp_lo_q[$];
    logic [31:0] exp_dz_q[$];
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;
    int          vectors;
    int          miscompares;

    muldiv_hilo_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op_div    (op_div),
        .is_signed (is_signed),
        .A         (A),
        .B         (B),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wdata     (wdata),
`ifdef MULDIV_ABORT_EN
        .abort     (abort),
`endif
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .outHI     (outHI),
        .outLO     (outLO)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference arithmetic model
    task automatic model(input logic dv, input logic sg, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic [31:0] dz);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
        dz = 32'd0;
        if (!dv) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
            dz = 32'd1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end
    endtask

    // Drive one request; returns #1 after the accepting edge
    task automatic apply_op(input logic dv, input logic sg, input logic [31:0] a,
                            input logic [31:0] b, input logic wr_hi);
        logic [31:0] eh, el, ed;
        model(dv, sg, a, b, eh, el, ed);
        exp_hi_q.push_back(eh);
        exp_lo_q.push_back(el);
        exp_dz_q.push_back(ed);
        @(negedge clk);
        start = 1'b1; op_div = dv; is_signed = sg; A = a; B = b;
        mthi = wr_hi; wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0; mthi = 1'b0;
    endtask

    // Wait for done (bounded), check latency and pop the scoreboard
    task automatic wait_result(input string tag, input int n0);
        int          n;
        logic        got;
        logic [31:0] eh, el, ed;
        n   = n0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (done === 1'b1) got = 1'b1;
        end
        check({tag, "_done_seen"}, {31'b0, got}, 32'd1);
        check({tag, "_latency"}, n, 32'd34);
        eh = exp_hi_q.pop_front();
        el = exp_lo_q.pop_front();
        ed = exp_dz_q.pop_front();
        check({tag, "_hi"}, outHI, eh);
        check({tag, "_lo"}, outLO, el);
        check({tag, "_div_zero"}, {31'b0, div_zero}, ed);
        cur_hi = eh;
        cur_lo = el;
    endtask

    // Watch a window of cycles and count any done pulse
    task automatic expect_no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        check(tag, seen, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, junk;
        logic        rdv, rsg;
        vectors     = 0;
        miscompares = 0;
        cur_hi      = 32'd0;
        cur_lo      = 32'd0;
        reset_n = 1'b0; start = 1'b0; op_div = 1'b0; is_signed = 1'b0;
        A = '0; B = '0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
`ifdef MULDIV_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_div_zero", {31'b0, div_zero}, 32'd0);
        check("rst_hi", outHI, 32'd0);
        check("rst_lo", outLO, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Unsigned max * max
        apply_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("umul_busy", {31'b0, busy}, 32'd1);
        wait_result("umul_max", 1);

        // Signed multiply and divide
        apply_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 1'b0);
        wait_result("smul_m3x7", 1);
        apply_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_result("sdiv_m7d2", 1);

        // Divide by zero, then the next accept clears the flag
        apply_op(1'b1, 1'b0, 32'd5, 32'd0, 1'b0);
        wait_result("div_by_zero", 1);
        apply_op(1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
        check("dz_cleared_on_accept", {31'b0, div_zero}, 32'd0);
        check("hi_held_while_busy", outHI, cur_hi);
        wait_result("udiv_100d7", 1);

        // Signed overflow case
        apply_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_result("sdiv_overflow", 1);

        // start and mthi during RUN are ignored
        apply_op(1'b0, 1'b0, 32'h1234_5678, 32'h0000_0100, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op_div = 1'b1; A = 32'd1; B = 32'd1; mthi = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk);
        #1;
        start = 1'b0; mthi = 1'b0;
        check("run_mthi_ignored", outHI, cur_hi);
        check("run_still_busy", {31'b0, busy}, 32'd1);
        wait_result("run_start_ignored", 6);
        expect_no_done("no_second_op", 40);

        // mthi + mtlo together in IDLE
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A_5A5A;
        @(posedge clk);
        #1;
        mthi = 1'b0; mtlo = 1'b0;
        cur_hi = 32'h5A5A_5A5A;
        cur_lo = 32'h5A5A_5A5A;
        check("mthi_write", outHI, 32'h5A5A_5A5A);
        check("mtlo_write", outLO, 32'h5A5A_5A5A);

        // start with mthi in the same cycle: write dropped
        apply_op(1'b0, 1'b1, 32'h0000_0003, 32'hFFFF_FFFB, 1'b1);
        check("start_wins_hi", outHI, cur_hi);
        check("start_wins_lo", outLO, cur_lo);
        wait_result("smul_3xm5", 1);

        // Back-to-back from DONE
        apply_op(1'b1, 1'b1, 32'd17, 32'hFFFF_FFFD, 1'b0);
        wait_result("b2b_first", 1);
        apply_op(1'b1, 1'b1, 32'hFFFF_FFEF, 32'd3, 1'b0);
        wait_result("b2b_second", 1);

        // Random operations
        for (int i = 0; i < 6; i++) begin
            rdv = 1'($urandom_range(0, 1));
            rsg = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            apply_op(rdv, rsg, ra, rb, 1'b0);
            wait_result("random_op", 1);
        end

        // Reset in RUN cycle 10
        apply_op(1'b0, 1'b0, 32'h0001_0001, 32'h0000_FFFF, 1'b0);
        junk = exp_hi_q.pop_back();
        junk = exp_lo_q.pop_back();
        junk = exp_dz_q.pop_back();
        repeat (9) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_ready", {31'b0, ready}, 32'd1);
        check("midrst_hi", outHI, 32'd0);
        check("midrst_lo", outLO, 32'd0);
        cur_hi = 32'd0;
        cur_lo = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        expect_no_done("midrst_no_done", 50);

`ifdef MULDIV_ABORT_EN
        @(negedge clk);
        mtlo = 1'b1; wdata = 32'h0000_AAAA;
        @(posedge clk);
        #1;
        mtlo = 1'b0;
        cur_lo = 32'h0000_AAAA;
        apply_op(1'b0, 1'b0, 32'd7, 32'd9, 1'b0);
        junk = exp_hi_q.pop_back();
        junk = exp_lo_q.pop_back();
        junk = exp_dz_q.pop_back();
        repeat (4) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_ready", {31'b0, ready}, 32'd1);
        check("abort_lo", outLO, 32'h0000_AAAA);
        check("abort_hi", outHI, cur_hi);
        check("abort_div_zero", {31'b0, div_zero}, 32'd0);
        expect_no_done("abort_no_done", 40);
`endif

        check("scoreboard_empty", exp_hi_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
